// File: rtl/reg_univ.sv
// reg_univ: WIDTH-bit SAP bus register with active-low load, tri-state bus drive and
// in-place inc/dec/shift/rotate/clear modes. Define REG_UNIV_SAT_EN for saturating inc/dec.
module reg_univ #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [WIDTH-1:0] in,
  input  logic             low_i_en,
  input  logic             low_o_en,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_INC  = 3'b001,
    MODE_DEC  = 3'b010,
    MODE_SHL  = 3'b011,
    MODE_SHR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_ROR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_r;
  logic             carry_r;
  logic [WIDTH-1:0] value_next_s;
  logic             carry_next_s;

  // Next-state selection: bus load beats any in-place mode.
  always_comb begin
    value_next_s = value_r;
    carry_next_s = carry_r;
    if (!low_i_en) begin
      value_next_s = in;
      carry_next_s = 1'b0;
    end else begin
      case (mode)
        MODE_HOLD: begin
          value_next_s = value_r;
          carry_next_s = carry_r;
        end
        MODE_INC: begin
          carry_next_s = (value_r == ONES_C);
`ifdef REG_UNIV_SAT_EN
          if (value_r == ONES_C) value_next_s = ONES_C;
          else                   value_next_s = value_r + ONE_C;
`else
          value_next_s = value_r + ONE_C;
`endif
        end
        MODE_DEC: begin
          carry_next_s = (value_r == ZERO_C);
`ifdef REG_UNIV_SAT_EN
          if (value_r == ZERO_C) value_next_s = ZERO_C;
          else                   value_next_s = value_r - ONE_C;
`else
          value_next_s = value_r - ONE_C;
`endif
        end
        MODE_SHL: begin
          value_next_s = {value_r[WIDTH-2:0], ser_in};
          carry_next_s = value_r[WIDTH-1];
        end
        MODE_SHR: begin
          value_next_s = {ser_in, value_r[WIDTH-1:1]};
          carry_next_s = value_r[0];
        end
        MODE_ROL: begin
          value_next_s = {value_r[WIDTH-2:0], value_r[WIDTH-1]};
          carry_next_s = value_r[WIDTH-1];
        end
        MODE_ROR: begin
          value_next_s = {value_r[0], value_r[WIDTH-1:1]};
          carry_next_s = value_r[0];
        end
        MODE_CLR: begin
          value_next_s = ZERO_C;
          carry_next_s = 1'b0;
        end
        default: begin
          value_next_s = value_r;
          carry_next_s = carry_r;
        end
      endcase
    end
  end

  // Register state; carry only changes on an edge, so release never glitches it.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      value_r <= RESET_VAL;
      carry_r <= 1'b0;
    end else begin
      value_r <= value_next_s;
      carry_r <= carry_next_s;
    end
  end

  assign value = value_r;
  assign carry = carry_r;
  assign zero  = (value_r == ZERO_C);
  assign out   = low_o_en ? {WIDTH{1'bz}} : value_r;

endmodule

// File: tb/tb_reg_univ.sv
// Self-checking bench for reg_univ (WIDTH=8, RESET_VAL=0): directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_reg_univ;

  logic       clk = 1'b0;
  logic       async_reset;
  logic [7:0] in;
  logic       low_i_en;
  logic       low_o_en;
  logic [2:0] mode;
  logic       ser_in;
  wire  [7:0] out_w;
  logic [7:0] value;
  logic       carry;
  logic       zero;

  int n_tests = 0;
  int n_fail  = 0;
  int m_val   = 0;
  int m_carry = 0;

  reg_univ #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .async_reset(async_reset), .in(in), .low_i_en(low_i_en),
    .low_o_en(low_o_en), .mode(mode), .ser_in(ser_in), .out(out_w),
    .value(value), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!async_reset && low_i_en)
      assert (!$isunknown(mode)) else $error("FAIL mode_x: mode=%b while low_i_en=1", mode);

  // Reference model: the rules computed with plain integer arithmetic on 0..255.
  task automatic model_step(input int ld, input int d, input int md, input int s);
    int v;
    v = m_val;
    if (ld == 0) begin
      m_val = d; m_carry = 0;
    end else begin
      case (md)
        1: begin
          m_carry = (v == 255) ? 1 : 0;
          m_val   = (v + 1) % 256;
`ifdef REG_UNIV_SAT_EN
          if (v == 255) m_val = 255;
`endif
        end
        2: begin
          m_carry = (v == 0) ? 1 : 0;
          m_val   = (v + 255) % 256;
`ifdef REG_UNIV_SAT_EN
          if (v == 0) m_val = 0;
`endif
        end
        3: begin m_carry = v / 128; m_val = (v * 2 + s) % 256;          end
        4: begin m_carry = v % 2;   m_val = v / 2 + s * 128;            end
        5: begin m_carry = v / 128; m_val = (v * 2) % 256 + v / 128;    end
        6: begin m_carry = v % 2;   m_val = v / 2 + (v % 2) * 128;      end
        7: begin m_carry = 0;       m_val = 0;                          end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle's controls (just after an edge), advance the model, clock, settle.
  task automatic do_edge(input logic ld, input logic [7:0] d, input logic [2:0] md, input logic s);
    low_i_en = ld; in = d; mode = md; ser_in = s;
    model_step(int'(ld), int'(d), int'(md), int'(s));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    async_reset = 1'b1; low_i_en = 1'b1; low_o_en = 1'b1; mode = 3'b000; in = 8'h00; ser_in = 1'b0;
    @(posedge clk); #1;
    async_reset = 1'b0; m_val = 0; m_carry = 0;
    do_edge(1'b0, 8'h5A, 3'b000, 1'b0);
    n_tests++; if (value !== 8'h5A) begin n_fail++; $display("FAIL pre_reset_load: value=%h expected=5a", value); end
    #3; async_reset = 1'b1; #1;
    m_val = 0; m_carry = 0;
    n_tests++; if (value !== 8'h00) begin n_fail++; $display("FAIL reset_value: value=%h expected=00", value); end
    n_tests++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: carry=%b expected=0", carry); end
    n_tests++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: zero=%b expected=1", zero); end
    low_o_en = 1'b0; #1;
    n_tests++; if (out_w !== 8'h00) begin n_fail++; $display("FAIL reset_out: out=%h expected=00", out_w); end
    async_reset = 1'b0;
    do_edge(1'b1, 8'h00, 3'b000, 1'b0);
    n_tests++; if (value !== 8'h00) begin n_fail++; $display("FAIL reset_hold: value=%h expected=00", value); end
  endtask

  task automatic test_incdec();
    do_edge(1'b0, 8'hFF, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b001, 1'b0);
`ifndef REG_UNIV_SAT_EN
    n_tests++; if (value !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
      n_fail++; $display("FAIL inc_wrap: value=%h carry=%b zero=%b expected=00/1/1", value, carry, zero); end
    do_edge(1'b1, 8'h00, 3'b010, 1'b0);
    n_tests++; if (value !== 8'hFF || carry !== 1'b1) begin
      n_fail++; $display("FAIL dec_wrap: value=%h carry=%b expected=ff/1", value, carry); end
`else
    do_edge(1'b0, 8'h00, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b001, 1'b0);
    do_edge(1'b0, 8'hFF, 3'b000, 1'b0);
`endif
    do_edge(1'b1, 8'h00, 3'b010, 1'b0);
    n_tests++; if (value !== 8'hFE || carry !== 1'b0) begin
      n_fail++; $display("FAIL dec_plain: value=%h carry=%b expected=fe/0", value, carry); end
  endtask

  task automatic test_load();
    do_edge(1'b0, 8'hFF, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b001, 1'b0);
    do_edge(1'b0, 8'hA5, 3'b001, 1'b0);
    n_tests++; if (value !== 8'hA5 || carry !== 1'b0) begin
      n_fail++; $display("FAIL load_priority: value=%h carry=%b expected=a5/0", value, carry); end
    for (int i = 0; i < 3; i++) do_edge(1'b1, 8'h3C, 3'b000, 1'b0);
    n_tests++; if (value !== 8'hA5) begin n_fail++; $display("FAIL hold_3: value=%h expected=a5", value); end
    low_o_en = 1'b1; #1;
    n_tests++; if (out_w === 8'hA5) begin n_fail++; $display("FAIL out_disabled: out=%h expected not driven", out_w); end
    low_o_en = 1'b0; low_i_en = 1'b0; in = 8'h3C; #1;
    n_tests++; if (out_w !== 8'hA5) begin n_fail++; $display("FAIL out_before_edge: out=%h expected=a5", out_w); end
    do_edge(1'b0, 8'h3C, 3'b000, 1'b0);
    n_tests++; if (out_w !== 8'h3C) begin n_fail++; $display("FAIL out_after_edge: out=%h expected=3c", out_w); end
  endtask

  task automatic test_shift_rotate();
    do_edge(1'b0, 8'h81, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b011, 1'b0);
    n_tests++; if (value !== 8'h02 || carry !== 1'b1) begin n_fail++; $display("FAIL shl: value=%h carry=%b expected=02/1", value, carry); end
    do_edge(1'b1, 8'h00, 3'b110, 1'b0);
    n_tests++; if (value !== 8'h01 || carry !== 1'b0) begin n_fail++; $display("FAIL ror1: value=%h carry=%b expected=01/0", value, carry); end
    do_edge(1'b1, 8'h00, 3'b110, 1'b0);
    n_tests++; if (value !== 8'h80 || carry !== 1'b1) begin n_fail++; $display("FAIL ror2: value=%h carry=%b expected=80/1", value, carry); end
    do_edge(1'b1, 8'h00, 3'b100, 1'b1);
    n_tests++; if (value !== 8'hC0 || carry !== 1'b0) begin n_fail++; $display("FAIL shr: value=%h carry=%b expected=c0/0", value, carry); end
    do_edge(1'b1, 8'h00, 3'b101, 1'b0);
    n_tests++; if (value !== 8'h81 || carry !== 1'b1) begin n_fail++; $display("FAIL rol: value=%h carry=%b expected=81/1", value, carry); end
    do_edge(1'b1, 8'h00, 3'b111, 1'b0);
    n_tests++; if (value !== 8'h00 || carry !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL clr: value=%h carry=%b zero=%b expected=00/0/1", value, carry, zero); end
  endtask

  task automatic test_reset_mid();
    do_edge(1'b0, 8'h10, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) do_edge(1'b1, 8'h00, 3'b001, 1'b0);
    n_tests++; if (value !== 8'h13) begin n_fail++; $display("FAIL count_3: value=%h expected=13", value); end
    #2; async_reset = 1'b1; #1;
    n_tests++; if (value !== 8'h00 || carry !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: value=%h carry=%b expected=00/0", value, carry); end
    #2; async_reset = 1'b0; m_val = 0; m_carry = 0;
    @(posedge clk); #1;
    model_step(1, 0, 1, 0);
    n_tests++; if (value !== 8'h01 || carry !== 1'b0) begin
      n_fail++; $display("FAIL release_inc: value=%h carry=%b expected=01/0", value, carry); end
  endtask

`ifdef REG_UNIV_SAT_EN
  task automatic test_saturation();
    do_edge(1'b0, 8'hFF, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b001, 1'b0);
    n_tests++; if (value !== 8'hFF || carry !== 1'b1) begin n_fail++; $display("FAIL sat_inc: value=%h carry=%b expected=ff/1", value, carry); end
    do_edge(1'b0, 8'h00, 3'b000, 1'b0);
    do_edge(1'b1, 8'h00, 3'b010, 1'b0);
    n_tests++; if (value !== 8'h00 || carry !== 1'b1) begin n_fail++; $display("FAIL sat_dec: value=%h carry=%b expected=00/1", value, carry); end
  endtask
`endif

  task automatic test_random();
    logic       ld;
    logic [7:0] d;
    logic [2:0] md;
    logic       s;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 3) != 0);
      // Bias loads toward the wrap/saturate corners.
      case ($urandom_range(0, 3))
        0:       d = 8'hFF;
        1:       d = 8'h00;
        default: d = 8'($urandom);
      endcase
      md = 3'($urandom);
      s  = 1'($urandom);
      low_o_en = 1'($urandom);
      do_edge(ld, d, md, s);
      n_tests++; if (int'(value) != m_val || int'(carry) != m_carry || zero !== (m_val == 0)) begin
        n_fail++; $display("FAIL rand_%0d: value=%h carry=%b zero=%b expected=%h/%0d/%0d",
                           i, value, carry, zero, m_val[7:0], m_carry, (m_val == 0)); end
      if (!low_o_en) begin
        n_tests++; if (int'(out_w) != m_val) begin n_fail++; $display("FAIL rand_out_%0d: out=%h expected=%h", i, out_w, m_val[7:0]); end
      end else if (m_val != 0) begin
        n_tests++; if (int'(out_w) == m_val) begin n_fail++; $display("FAIL rand_hiz_%0d: out=%h expected not driven", i, out_w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_incdec();
    test_load();
    test_shift_rotate();
    test_reset_mid();
`ifdef REG_UNIV_SAT_EN
    test_saturation();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
